// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg
// Shared types and helpers for the 4-byte test-memory responder.
//   mem_req_4B_t  : type_, opaque, addr, len, data (request message)
//   mem_resp_4B_t : type_, opaque, test, len, data (response message)
//   byte_en()     : byte-lane enables for a (len, offset) access
//   write_align() : moves request data from bit 0 up to the byte offset
//   read_align()  : moves selected bytes down to bit 0, zero-extended
package mem_responder_pkg;

    localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
    localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;

    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

    // Lanes covered by an access of the given length starting at byte 0.
    // len=0 encodes a full word.
    function automatic logic [3:0] len_mask(input logic [1:0] len);
        logic [3:0] m;
        case (len)
            2'd0:    m = 4'b1111;
            2'd1:    m = 4'b0001;
            2'd2:    m = 4'b0011;
            2'd3:    m = 4'b0111;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Lanes past byte 3 fall off the top of the widened mask and are dropped.
    function automatic logic [3:0] byte_en(input logic [1:0] len, input logic [1:0] off);
        logic [7:0] wide;
        wide = {4'b0000, len_mask(len)} << off;
        return wide[3:0];
    endfunction

    function automatic logic [31:0] write_align(input logic [31:0] data, input logic [1:0] off);
        return data << {off, 3'b000};
    endfunction

    function automatic logic [31:0] read_align(input logic [31:0] word, input logic [1:0] len,
                                               input logic [1:0] off);
        logic [31:0] shifted;
        logic [3:0]  m;
        logic [31:0] r;
        shifted = word >> {off, 3'b000};
        m       = len_mask(len);
        r       = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                r[8*i +: 8] = shifted[8*i +: 8];
            end else begin
                r[8*i +: 8] = 8'h00;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_responder_resp_fifo.sv
// mem_responder_resp_fifo
// Bypass FIFO holding responses that leave the latency pipeline while the
// consumer is stalled. When empty, an arriving entry is presented on the
// output in the same cycle and is not stored if it is taken immediately.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   enq_val, enq_msg    : entry arriving from the pipeline
//   deq_val, deq_msg    : head entry (or bypassed arrival)
//   deq_rdy             : head entry consumed this cycle
module mem_responder_resp_fifo #(
    parameter int p_width = 47,
    parameter int p_depth = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enq_val,
    input  logic [p_width-1:0] enq_msg,
    output logic               deq_val,
    output logic [p_width-1:0] deq_msg,
    input  logic               deq_rdy
);

    localparam int PW = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int CW = $clog2(p_depth + 1);

    logic [p_width-1:0] buf_q [p_depth];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               empty_s;
    logic               push_s;
    logic               pop_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] n;
        if (p == PW'(p_depth - 1)) begin
            n = '0;
        end else begin
            n = p + PW'(1);
        end
        return n;
    endfunction

    // Output selection, push/pop decisions and next-state for pointers/count.
    always_comb begin
        empty_s  = (count_q == CW'(0));
        deq_val  = 1'b0;
        deq_msg  = '0;
        pop_s    = 1'b0;
        push_s   = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (empty_s) begin
            deq_val = enq_val;
            deq_msg = enq_msg;
        end else begin
            deq_val = 1'b1;
            deq_msg = buf_q[rd_ptr_q];
        end

        pop_s = !empty_s && deq_rdy;
        // An arrival into an empty FIFO that is consumed at once never lands.
        // The occupancy guard keeps a full FIFO from being overwritten.
        push_s = enq_val && !(empty_s && deq_rdy) &&
                 ((count_q < CW'(p_depth)) || pop_s);

        if (push_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful below the count.
    always_ff @(posedge clk) begin
        if (push_s) begin
            buf_q[wr_ptr_q] <= enq_msg;
        end
    end

endmodule

// File: rtl/mem_responder_4b.sv
// mem_responder_4b
// Far-end responder for the 4-byte val/rdy memory interface. Requests
// read/write an internal word array; responses return in order after
// p_latency cycles, buffered in a bypass FIFO under backpressure. A credit
// counter limits in-flight plus buffered responses to p_resp_depth.
// Ports:
//   clk, reset_n             : clock, asynchronous active-low reset
//   memreq_msg/val/rdy       : request channel
//   memresp_msg/val/rdy      : response channel
// Build option:
//   MEM_RESPONDER_RAND_DELAY_EN : a 16-bit LFSR randomly masks memresp_val
//   to exercise consumer tolerance of response gaps.
module mem_responder_4b
    import mem_responder_pkg::*;
#(
    parameter int p_mem_nwords = 256,
    parameter int p_latency    = 2,
    parameter int p_resp_depth = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  mem_req_4B_t  memreq_msg,
    input  logic         memreq_val,
    output logic         memreq_rdy,
    output mem_resp_4B_t memresp_msg,
    output logic         memresp_val,
    input  logic         memresp_rdy
);

    localparam int AW = $clog2(p_mem_nwords);
    localparam int CW = $clog2(p_resp_depth + 1);

    logic [31:0]   mem_q [p_mem_nwords];
    logic          req_fire_s;
    logic          resp_fire_s;
    logic [AW-1:0] word_idx_s;
    logic [1:0]    byte_off_s;
    logic [31:0]   rd_word_s;
    logic [3:0]    wr_be_s;
    logic [31:0]   wr_data_s;
    logic          is_write_s;
    mem_resp_4B_t  new_resp_s;

    logic               pipe_val_q [p_latency];
    logic               pipe_val_d [p_latency];
    mem_resp_4B_t       pipe_msg_q [p_latency];
    mem_resp_4B_t       pipe_msg_d [p_latency];

    logic [CW-1:0] outstanding_q, outstanding_d;
    logic          req_rdy_q, req_rdy_d;

    logic          fifo_deq_val_s;
    logic          fifo_deq_rdy_s;
    logic [$bits(mem_resp_4B_t)-1:0] fifo_deq_msg_s;
    logic          mask_s;
    logic          unused_addr_s;

    // Upper address bits wrap away; fold them so the whole field is consumed.
    assign unused_addr_s = ^memreq_msg.addr;

    assign memreq_rdy = req_rdy_q;

    // Request decode, array read and response formation for the accepting cycle.
    always_comb begin
        req_fire_s = memreq_val && req_rdy_q;
        word_idx_s = memreq_msg.addr[2 +: AW];
        byte_off_s = memreq_msg.addr[1:0];
        rd_word_s  = mem_q[word_idx_s];
        wr_be_s    = byte_en(memreq_msg.len, byte_off_s);
        wr_data_s  = write_align(memreq_msg.data, byte_off_s);
        is_write_s = (memreq_msg.type_ == MEM_TYPE_WRITE);

        new_resp_s        = '0;
        new_resp_s.type_  = memreq_msg.type_;
        new_resp_s.opaque = memreq_msg.opaque;
        new_resp_s.test   = 2'b00;
        new_resp_s.len    = memreq_msg.len;
        if (memreq_msg.type_ == MEM_TYPE_READ) begin
            new_resp_s.data = read_align(rd_word_s, memreq_msg.len, byte_off_s);
        end else begin
            new_resp_s.data = 32'h0000_0000;
        end
    end

    // Word array: writes commit on the accepting edge so a following read sees them.
    always_ff @(posedge clk) begin
        if (req_fire_s && is_write_s) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be_s[i]) begin
                    mem_q[word_idx_s][8*i +: 8] <= wr_data_s[8*i +: 8];
                end
            end
        end
    end

    // Latency pipeline next-state: always shifts, stage 0 takes the new response.
    always_comb begin
        for (int i = 0; i < p_latency; i++) begin
            pipe_val_d[i] = 1'b0;
            pipe_msg_d[i] = '0;
        end
        pipe_val_d[0] = req_fire_s;
        pipe_msg_d[0] = new_resp_s;
        for (int i = 1; i < p_latency; i++) begin
            pipe_val_d[i] = pipe_val_q[i-1];
            pipe_msg_d[i] = pipe_msg_q[i-1];
        end
    end

    // Latency pipeline registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < p_latency; i++) begin
                pipe_val_q[i] <= 1'b0;
                pipe_msg_q[i] <= '0;
            end
        end else begin
            pipe_val_q <= pipe_val_d;
            pipe_msg_q <= pipe_msg_d;
        end
    end

    mem_responder_resp_fifo #(
        .p_width ($bits(mem_resp_4B_t)),
        .p_depth (p_resp_depth)
    ) u_resp_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .enq_val (pipe_val_q[p_latency-1]),
        .enq_msg (pipe_msg_q[p_latency-1]),
        .deq_val (fifo_deq_val_s),
        .deq_msg (fifo_deq_msg_s),
        .deq_rdy (fifo_deq_rdy_s)
    );

`ifdef MEM_RESPONDER_RAND_DELAY_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR, taps 16,14,13,11.
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    // LFSR state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign mask_s = (lfsr_q[1:0] == 2'b00);
`else
    assign mask_s = 1'b0;
`endif

    // Response channel: a masked cycle hides the head without consuming it.
    always_comb begin
        memresp_val    = fifo_deq_val_s && !mask_s;
        fifo_deq_rdy_s = memresp_rdy && !mask_s;
        resp_fire_s    = memresp_val && memresp_rdy;
        if (memresp_val) begin
            memresp_msg = mem_resp_4B_t'(fifo_deq_msg_s);
        end else begin
            memresp_msg = '0;
        end
    end

    // Credit accounting; ready is registered from the next count.
    always_comb begin
        outstanding_d = outstanding_q;
        case ({req_fire_s, resp_fire_s})
            2'b10:   outstanding_d = outstanding_q + CW'(1);
            2'b01:   outstanding_d = outstanding_q - CW'(1);
            default: outstanding_d = outstanding_q;
        endcase
        req_rdy_d = (outstanding_d < CW'(p_resp_depth));
    end

    // Credit counter and request-ready registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outstanding_q <= '0;
            req_rdy_q     <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            req_rdy_q     <= req_rdy_d;
        end
    end

endmodule

// File: tb/tb_mem_responder_4b.sv
module tb_mem_responder_4b;
    import mem_responder_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n;
    mem_req_4B_t  memreq_msg;
    logic         memreq_val;
    logic         memreq_rdy;
    mem_resp_4B_t memresp_msg;
    logic         memresp_val;
    logic         memresp_rdy;

    int n_vec = 0;
    int n_err = 0;

    mem_req_4B_t  req_q [$];
    mem_resp_4B_t exp_q [$];

    always #5 clk = ~clk;

    mem_responder_4b dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .memreq_msg  (memreq_msg),
        .memreq_val  (memreq_val),
        .memreq_rdy  (memreq_rdy),
        .memresp_msg (memresp_msg),
        .memresp_val (memresp_val),
        .memresp_rdy (memresp_rdy)
    );

`ifdef MEM_RESPONDER_RAND_DELAY_EN
    logic [15:0] m_lfsr;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m_lfsr <= 16'hACE1;
        else          m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
`endif

    function automatic mem_req_4B_t mk_req(input logic [2:0] t, input logic [7:0] op,
                                           input logic [31:0] a, input logic [1:0] l,
                                           input logic [31:0] d);
        mem_req_4B_t r;
        r.type_ = t; r.opaque = op; r.addr = a; r.len = l; r.data = d;
        return r;
    endfunction

    function automatic mem_resp_4B_t mk_resp(input logic [2:0] t, input logic [7:0] op,
                                             input logic [1:0] l, input logic [31:0] d);
        mem_resp_4B_t r;
        r.type_ = t; r.opaque = op; r.test = 2'b00; r.len = l; r.data = d;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue req_q back-to-back with memresp_rdy=1; responses due 2 cycles later.
    task automatic run_burst(input string tag);
        int n;
        n = req_q.size();
        for (int c = 0; c < n + 2; c++) begin
            if (c < n) begin
                memreq_msg = req_q[c];
                memreq_val = 1'b1;
            end else begin
                memreq_msg = '0;
                memreq_val = 1'b0;
            end
            @(negedge clk);
            if (c < n) chk($sformatf("%s_rdy%0d", tag, c), 80'(memreq_rdy), 80'd1);
            if (c >= 2) chk($sformatf("%s_resp%0d", tag, c - 2),
                            80'({memresp_val, memresp_msg}), 80'({1'b1, exp_q[c-2]}));
            else        chk($sformatf("%s_idle%0d", tag, c), 80'(memresp_val), 80'd0);
            tick();
        end
        @(negedge clk);
        chk($sformatf("%s_drained", tag), 80'(memresp_val), 80'd0);
        tick();
        req_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int acc;
        reset_n     = 1'b0;
        memreq_val  = 1'b0;
        memreq_msg  = '0;
        memresp_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_req_rdy", 80'(memreq_rdy), 80'd0);
        chk("rst_resp_val", 80'(memresp_val), 80'd0);
        chk("rst_resp_msg", 80'(memresp_msg), 80'd0);
        tick();
        reset_n = 1'b1;
        tick();
        @(negedge clk);
        chk("rdy_after_reset", 80'(memreq_rdy), 80'd1);
        tick();

`ifndef MEM_RESPONDER_RAND_DELAY_EN
        // 1: full-word write then read, opaque echoed
        req_q.push_back(mk_req(MEM_TYPE_WRITE, 8'h11, 32'h10, 2'd0, 32'hDEADBEEF));
        req_q.push_back(mk_req(MEM_TYPE_READ,  8'h22, 32'h10, 2'd0, 32'h0));
        exp_q.push_back(mk_resp(MEM_TYPE_WRITE, 8'h11, 2'd0, 32'h0));
        exp_q.push_back(mk_resp(MEM_TYPE_READ,  8'h22, 2'd0, 32'hDEADBEEF));
        run_burst("t1");

        // 2: sub-word write and sub-word read alignment
        req_q.push_back(mk_req(MEM_TYPE_WRITE, 8'h31, 32'h20, 2'd0, 32'h11223344));
        req_q.push_back(mk_req(MEM_TYPE_WRITE, 8'h32, 32'h22, 2'd1, 32'h000000AB));
        req_q.push_back(mk_req(MEM_TYPE_READ,  8'h33, 32'h20, 2'd0, 32'h0));
        req_q.push_back(mk_req(MEM_TYPE_READ,  8'h34, 32'h21, 2'd2, 32'h0));
        exp_q.push_back(mk_resp(MEM_TYPE_WRITE, 8'h31, 2'd0, 32'h0));
        exp_q.push_back(mk_resp(MEM_TYPE_WRITE, 8'h32, 2'd1, 32'h0));
        exp_q.push_back(mk_resp(MEM_TYPE_READ,  8'h33, 2'd0, 32'h11AB3344));
        exp_q.push_back(mk_resp(MEM_TYPE_READ,  8'h34, 2'd2, 32'h0000AB33));
        run_burst("t2");

        // 4: preload words for later steps, then address wrap
        for (int i = 0; i < 4; i++) begin
            req_q.push_back(mk_req(MEM_TYPE_WRITE, 8'(8'h40 + i), 32'(32'h40 + 4 * i), 2'd0,
                                   32'(32'hC0DE0000 + i)));
            exp_q.push_back(mk_resp(MEM_TYPE_WRITE, 8'(8'h40 + i), 2'd0, 32'h0));
        end
        req_q.push_back(mk_req(MEM_TYPE_WRITE, 8'h45, 32'h400, 2'd0, 32'h5A5A5A5A));
        req_q.push_back(mk_req(MEM_TYPE_READ,  8'h46, 32'h000, 2'd0, 32'h0));
        exp_q.push_back(mk_resp(MEM_TYPE_WRITE, 8'h45, 2'd0, 32'h0));
        exp_q.push_back(mk_resp(MEM_TYPE_READ,  8'h46, 2'd0, 32'h5A5A5A5A));
        run_burst("t4");

        // 3: backpressure fills credits, then drains in order
        memresp_rdy = 1'b0;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            memreq_msg = mk_req(MEM_TYPE_READ, 8'(8'h50 + acc), 32'(32'h40 + 4 * acc), 2'd0, 32'h0);
            memreq_val = 1'b1;
            @(negedge clk);
            if (memreq_rdy) acc++;
            tick();
        end
        memreq_val = 1'b0;
        chk("t3_accepted", 80'(acc), 80'd4);
        @(negedge clk);
        chk("t3_rdy_full", 80'(memreq_rdy), 80'd0);
        chk("t3_val_held", 80'(memresp_val), 80'd1);
        tick();
        memresp_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("t3_resp%0d", k), 80'({memresp_val, memresp_msg}),
                80'({1'b1, mk_resp(MEM_TYPE_READ, 8'(8'h50 + k), 2'd0, 32'(32'hC0DE0000 + k))}));
            if (k == 0) chk("t3_rdy_first_deq", 80'(memreq_rdy), 80'd0);
            if (k == 1) chk("t3_rdy_back", 80'(memreq_rdy), 80'd1);
            tick();
        end
        @(negedge clk);
        chk("t3_drained", 80'(memresp_val), 80'd0);
        tick();

        // 5: reset with three outstanding responses
        memresp_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            memreq_msg = mk_req(MEM_TYPE_READ, 8'(8'h60 + i), 32'(32'h40 + 4 * i), 2'd0, 32'h0);
            memreq_val = 1'b1;
            tick();
        end
        memreq_val = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("t5_val_before", 80'(memresp_val), 80'd1);
        tick();
        reset_n = 1'b0;
        #1;
        chk("t5_val_in_reset", 80'(memresp_val), 80'd0);
        chk("t5_msg_in_reset", 80'(memresp_msg), 80'd0);
        chk("t5_rdy_in_reset", 80'(memreq_rdy), 80'd0);
        tick();
        memresp_rdy = 1'b1;
        reset_n = 1'b1;
        tick();
        @(negedge clk);
        chk("t5_rdy_after", 80'(memreq_rdy), 80'd1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t5_no_stale%0d", i), 80'(memresp_val), 80'd0);
            tick();
            @(negedge clk);
        end
        tick();
        req_q.push_back(mk_req(MEM_TYPE_READ, 8'h70, 32'h44, 2'd0, 32'h0));
        exp_q.push_back(mk_resp(MEM_TYPE_READ, 8'h70, 2'd0, 32'hC0DE0001));
        run_burst("t5_post");
`else
        // 6: random backpressure with masked response valid
        begin
            int sent, got, masked;
            for (int i = 0; i < 100; i++) begin
                req_q.push_back(mk_req(MEM_TYPE_WRITE, 8'(i), 32'(32'h200 + 4 * i), 2'd0,
                                       32'(32'h1000_0000 + 32'h0101 * i)));
                exp_q.push_back(mk_resp(MEM_TYPE_WRITE, 8'(i), 2'd0, 32'h0));
            end
            for (int i = 0; i < 100; i++) begin
                req_q.push_back(mk_req(MEM_TYPE_READ, 8'(8'h80 + i), 32'(32'h200 + 4 * i), 2'd0, 32'h0));
                exp_q.push_back(mk_resp(MEM_TYPE_READ, 8'(8'h80 + i), 2'd0,
                                        32'(32'h1000_0000 + 32'h0101 * i)));
            end
            sent = 0; got = 0; masked = 0;
            for (int c = 0; c < 3000 && got < 200; c++) begin
                if (sent < 200) begin
                    memreq_msg = req_q[sent];
                    memreq_val = 1'b1;
                end else begin
                    memreq_msg = '0;
                    memreq_val = 1'b0;
                end
                memresp_rdy = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                if (m_lfsr[1:0] == 2'b00) begin
                    masked++;
                    chk("t6_mask", 80'(memresp_val), 80'd0);
                end
                if (memresp_val && memresp_rdy) begin
                    chk($sformatf("t6_resp%0d", got), 80'(memresp_msg), 80'(exp_q[got]));
                    got++;
                end
                if (memreq_val && memreq_rdy) sent++;
                tick();
            end
            memreq_val = 1'b0;
            chk("t6_all_resp", 80'(got), 80'd200);
            chk("t6_masked_seen", 80'(masked > 0), 80'd1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_responder_4b.md
Name: mem_responder_4b

Overview:
- Single-port test-memory responder: the far end of the 4-byte val/rdy memory request/response interface that processor cores drive on imem and dmem.
- Accepts mem_req_4B_t requests and reads/writes an internal word array.
- Returns mem_resp_4B_t responses in order after a fixed pipeline latency.
- Buffers responses under backpressure, with credit-based request flow control.

Parameters:
- p_mem_nwords, 256, number of 32-bit words in the array; power of two, >=2.
- p_latency, 2, request-to-response pipeline stages; >=1.
- p_resp_depth, 4, maximum outstanding requests (in pipeline plus buffered); >=1.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- memreq_msg  in  $bits(mem_req_4B_t)  request: type_, opaque, addr, len, data.
- memreq_val  in  1  request valid.
- memreq_rdy  out  1  request ready.
- memresp_msg  out  $bits(mem_resp_4B_t)  response: type_, opaque, test, len, data.
- memresp_val  out  1  response valid.
- memresp_rdy  in  1  response ready.

Behaviour:
- Reset and clocking:
  - One clock, clk. Reset is asynchronous and active-low (reset_n).
  - While reset_n=0: memreq_rdy=0, memresp_val=0, memresp_msg=0, all pipeline valid bits cleared, response buffer empty, outstanding count=0.
  - Array contents are not reset.
  - Reset asserted mid-operation discards all in-flight and buffered responses immediately.
- Handshake:
  - A transfer fires on the rising edge when val&&rdy.
  - memreq_rdy = (outstanding < p_resp_depth). It depends only on state, never combinationally on memreq_val.
  - memresp_val never depends combinationally on memresp_rdy.
- Outstanding counter, width $clog2(p_resp_depth+1):
  - +1 on request fire, -1 on response fire; a simultaneous fire leaves it unchanged.
  - A full buffer cannot overflow.
- Addressing:
  - Word index = addr[2 +: $clog2(p_mem_nwords)]. Upper bits are ignored, so addresses wrap modulo the array size.
  - Byte offset = addr[1:0].
- Length: len=0 means 4 bytes; len=1/2/3 means that many bytes starting at the byte offset. Bytes past byte 3 are dropped (no carry into the next word).
- Write (type_=1):
  - Enabled bytes are written on the accepting edge.
  - Response data=0.
- Read (type_=0):
  - The word is read combinationally in the accepting cycle.
  - Selected bytes are shifted to bit 0 and zero-extended.
  - Because writes commit at acceptance, a read accepted after a write always sees the written data, including back-to-back cycles.
- Other type_ values (AMOs, init): no array change; response data=0.
- Response fields: type_ and opaque are echoed, test=0, len is echoed.
- Latency:
  - The response enters a p_latency-stage valid/data shift pipeline at acceptance.
  - The last stage feeds a bypass FIFO of depth p_resp_depth.
  - With an empty FIFO and memresp_rdy=1, memresp_val rises exactly p_latency cycles after the accepting cycle.
  - Full throughput is one request per cycle.
- Stall:
  - Pipeline stages always advance; a credit is guaranteed FIFO space.
  - When memresp_rdy=0 the FIFO fills. At full, outstanding == p_resp_depth, so memreq_rdy drops.
  - A response dequeue and pipeline arrival in the same cycle are both accepted (count unchanged).
- Responses are strictly in request order.

Optional Feature:
- Macro: MEM_RESPONDER_RAND_DELAY_EN.
- When defined:
  - A 16-bit Fibonacci LFSR (seed 16'hACE1, taps 16,14,13,11) advances every cycle.
  - memresp_val is masked to 0 in cycles where lfsr[1:0]==2'b00. Order and data are unaffected.
  - The LFSR resets to the seed.
- When undefined: no LFSR, no masking; latency is exactly as above.

Decomposition:
- Shared package mem_responder_pkg:
  - MEM_TYPE_READ=3'd0, MEM_TYPE_WRITE=3'd1.
  - Byte-enable function from (len, offset).
  - Read-align function.
- mem_req_4B_t and mem_resp_4B_t come from the existing memory message definitions.
- Natural sub-module: mem_responder_resp_fifo, a bypass FIFO with async active-low reset, because the existing queue uses a synchronous active-high reset.

Test Plan:
1. Write addr=0x10 data=0xDEADBEEF len=0, then read addr=0x10, p_latency=2, memresp_rdy=1 -> write response (type_=1, data=0) in cycle 2; read response data=0xDEADBEEF one cycle later; opaque echoed.
2. Write 0x11223344 at 0x20, write len=1 data=0xAB at addr 0x22, read 0x20 -> 0x11AB3344; read len=2 at 0x21 -> 0x0000AB33.
3. Hold memresp_rdy=0 with 10 back-to-back reads -> exactly 4 accepted, then memreq_rdy=0; release -> 4 responses in order, memreq_rdy=1 the cycle after the first dequeue.
4. p_mem_nwords=256: write 0x5A5A5A5A at 0x400, read 0x000 -> 0x5A5A5A5A (wrap).
5. Assert reset_n=0 mid-stream with 3 outstanding -> memresp_val=0 immediately, no stale responses after release, memreq_rdy=1 the first cycle after release.
6. With MEM_RESPONDER_RAND_DELAY_EN, 100 reads of preloaded distinct words under random memresp_rdy -> all 100 responses correct and in order; memresp_val observed masked at least once.
